// File: rtl/demux16_deser.sv
// -----------------------------------------------------------------------------
// demux16_deser: sequenced 1-to-WIDTH demultiplexer / deserializer.
//
// Collects one serial bit per accepted beat into successive slots of a
// WIDTH-bit word. A frame starts on a beat flagged in_sof. The finished word
// is presented on a valid/ready output port.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_bit / in_sof qualify this cycle
//   in_bit     serial data bit
//   in_sof     bit is slot 0 of a new frame
//   in_ready   beat accepted when in_valid && in_ready (combinational from state)
//   out_data   assembled word (registered)
//   out_valid  out_data holds an unconsumed word (registered)
//   out_ready  downstream consumes the word
//   slot       bits collected in the current frame, 0 when idle
//   frame_err  one-cycle pulse when a frame is abandoned by an early in_sof
// -----------------------------------------------------------------------------
module demux16_deser #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    slot,
    output logic             frame_err
);

    localparam logic [CW:0]   LAST_CNT = (CW+1)'(WIDTH - 1);
    localparam logic [CW-1:0] TOP_POS  = CW'(WIDTH - 1);
    localparam logic [CW:0]   ONE_CNT  = (CW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FULL    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             accept;
    logic             out_free;
    logic [CW-1:0]    wr_pos;
    logic [CW-1:0]    sof_pos;
    logic [WIDTH-1:0] asm_wr;
    logic [WIDTH-1:0] asm_sof;

    // Handshake qualifiers
    always_comb begin
        in_ready = !rst && (state_q != S_FULL);
        accept   = in_valid && in_ready;
        // Output register can take a word this edge if empty or being drained.
        out_free = !out_valid_q || out_ready;
    end

    // Slot position mapping and candidate assembly words
    always_comb begin
        wr_pos  = MSB_FIRST ? (TOP_POS - CW'(cnt_q)) : CW'(cnt_q);
        sof_pos = MSB_FIRST ? TOP_POS : '0;
        asm_wr          = asm_q;
        asm_wr[wr_pos]  = in_bit;
        // A new frame clears any partial content from an abandoned frame.
        asm_sof          = '0;
        asm_sof[sof_pos] = in_bit;
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Beats without in_sof are dropped until a frame starts.
                if (accept && in_sof) begin
                    asm_d   = asm_sof;
                    cnt_d   = ONE_CNT;
                    state_d = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (accept) begin
                    if (in_sof) begin
                        frame_err_d = 1'b1;
                        asm_d       = asm_sof;
                        cnt_d       = ONE_CNT;
                    end else if (cnt_q == LAST_CNT) begin
                        if (out_free) begin
                            out_data_d  = asm_wr;
                            out_valid_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = S_IDLE;
                        end else begin
                            // Park the finished word; slot stays at the last index.
                            asm_d   = asm_wr;
                            state_d = S_FULL;
                        end
                    end else begin
                        asm_d = asm_wr;
                        cnt_d = cnt_q + ONE_CNT;
                    end
                end
            end

            S_FULL: begin
                if (out_free) begin
                    out_data_d  = asm_q;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign slot      = cnt_q[CW-1:0];

endmodule

// File: tb/tb_demux16_deser.sv
// -----------------------------------------------------------------------------
// tb_demux16_deser: scoreboard bench for demux16_deser. Two instances
// (LSB-first and MSB-first) share one input stream; each has its own queue of
// expected words, popped by a monitor on every output transfer.
// -----------------------------------------------------------------------------
module tb_demux16_deser;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        in_sof;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic [15:0] out_data0, out_data1;
    logic        out_valid0, out_valid1;
    logic [3:0]  slot0, slot1;
    logic        frame_err0, frame_err1;

    int          n_checks;
    int          n_fail;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    demux16_deser #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .in_sof(in_sof), .in_ready(in_ready0), .out_data(out_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .slot(slot0),
        .frame_err(frame_err0)
    );

    demux16_deser #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .in_sof(in_sof), .in_ready(in_ready1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .slot(slot1),
        .frame_err(frame_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; presents one beat and returns at the following posedge+1.
    task automatic beat(input logic b, input logic s);
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] w);
        for (int k = 0; k < 16; k++) beat(w[k], k == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] e0, input logic [15:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    // Output monitors: a transfer happens at the next posedge when both are high.
    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready) begin
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL lsb_unexpected_word: got %0h expected none", out_data0);
            end else begin
                logic [15:0] e;
                e = q0.pop_front();
                if (out_data0 !== e) begin
                    n_fail++;
                    $display("FAIL lsb_word: got %0h expected %0h", out_data0, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL msb_unexpected_word: got %0h expected none", out_data1);
            end else begin
                logic [15:0] e;
                e = q1.pop_front();
                if (out_data1 !== e) begin
                    n_fail++;
                    $display("FAIL msb_word: got %0h expected %0h", out_data1, e);
                end
            end
        end
    end

    initial begin
        logic [15:0] w;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_out_data", 32'(out_data0), 32'd0);
        chk("rst_slot", 32'(slot0), 32'd0);
        chk("rst_frame_err", 32'(frame_err0), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready0), 32'd1);

        // Frame 3F0A, slot counts and one-cycle latency
        push(16'h3F0A, 16'h50FC);
        w = 16'h3F0A;
        for (int k = 0; k < 16; k++) begin
            beat(w[k], k == 0);
            chk("t1_slot", 32'(slot0), (k == 15) ? 32'd0 : 32'(k + 1));
        end
        chk("t1_out_valid", 32'(out_valid0), 32'd1);
        chk("t1_lsb_data", 32'(out_data0), 32'h3F0A);
        chk("t1_msb_data", 32'(out_data1), 32'h50FC);
        idle(1);
        chk("t1_valid_clear", 32'(out_valid0), 32'd0);

        // Back-to-back frames with stalled output
        out_ready = 1'b0;
        push(16'h0006, 16'h6000);
        push(16'h000C, 16'h3000);
        send_frame(16'h0006);
        send_frame(16'h000C);
        chk("t3_in_ready_full", 32'(in_ready0), 32'd0);
        chk("t3_in_ready_full_msb", 32'(in_ready1), 32'd0);
        idle(2);
        chk("t3_hold_valid", 32'(out_valid0), 32'd1);
        chk("t3_hold_data", 32'(out_data0), 32'h0006);
        out_ready = 1'b1;
        idle(1);
        chk("t3_second_valid", 32'(out_valid0), 32'd1);
        chk("t3_second_data", 32'(out_data0), 32'h000C);
        chk("t3_in_ready_back", 32'(in_ready0), 32'd1);
        idle(1);
        out_ready = 1'b0;
        chk("t3_drained", 32'(out_valid0), 32'd0);
        out_ready = 1'b1;

        // Beats before any in_sof are dropped
        for (int k = 0; k < 5; k++) begin
            beat(1'b1, 1'b0);
            chk("t4_drop_slot", 32'(slot0), 32'd0);
        end
        push(16'hFFFF, 16'hFFFF);
        send_frame(16'hFFFF);
        chk("t4_data", 32'(out_data0), 32'hFFFF);
        idle(1);

        // Frame aborted at slot 7, then A5A5
        beat(1'b1, 1'b1);
        for (int k = 0; k < 6; k++) beat(1'b1, 1'b0);
        chk("t5_slot7", 32'(slot0), 32'd7);
        chk("t5_no_err_yet", 32'(frame_err0), 32'd0);
        push(16'hA5A5, 16'hA5A5);
        w = 16'hA5A5;
        beat(w[0], 1'b1);
        chk("t5_err_pulse", 32'(frame_err0), 32'd1);
        chk("t5_err_pulse_msb", 32'(frame_err1), 32'd1);
        chk("t5_restart_slot", 32'(slot0), 32'd1);
        beat(w[1], 1'b0);
        chk("t5_err_one_cycle", 32'(frame_err0), 32'd0);
        for (int k = 2; k < 16; k++) beat(w[k], 1'b0);
        chk("t5_data", 32'(out_data0), 32'hA5A5);
        idle(3);

        // Reset mid-frame with a held word
        out_ready = 1'b0;
        send_frame(16'h1234);
        w = 16'h00FF;
        for (int k = 0; k < 9; k++) beat(w[k], k == 0);
        chk("t6_slot9", 32'(slot0), 32'd9);
        chk("t6_held", 32'(out_valid0), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_in_ready_in_rst", 32'(in_ready0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_out_valid", 32'(out_valid0), 32'd0);
        chk("t6_out_data", 32'(out_data0), 32'd0);
        chk("t6_slot", 32'(slot0), 32'd0);
        chk("t6_in_ready", 32'(in_ready0), 32'd1);
        chk("t6_frame_err", 32'(frame_err0), 32'd0);
        out_ready = 1'b1;
        idle(4);

        chk("final_q_lsb_empty", 32'(q0.size()), 32'd0);
        chk("final_q_msb_empty", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux16_deser.md
Name: demux16_deser

Overview:
Sequenced 1-to-16 demultiplexer and deserializer. It steers a stream of single bits, one per accepted beat, into successive slots of a WIDTH-bit word. The completed word is presented on a valid/ready output port. It is the receive-side counterpart of our 16:1 bit-select mux path and rebuilds parallel words from a serial bit stream framed by a start-of-frame marker.

Parameters:
WIDTH, 16, number of slots per frame and output word width; legal range 2..32.
MSB_FIRST, 0, slot order. 0: k-th bit of frame goes to out_data[k]. 1: k-th bit goes to out_data[WIDTH-1-k].
CW, $clog2(WIDTH), derived; width of the slot counter. Not overridden.

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_bit/in_sof are valid this cycle.
in_bit  input  1  serial data bit.
in_sof  input  1  marks the bit as slot 0 of a new frame.
in_ready  output  1  block accepts a beat this cycle. A beat is accepted when in_valid && in_ready.
out_data  output  WIDTH  assembled word.
out_valid  output  1  out_data holds an unconsumed word.
out_ready  input  1  downstream consumes the word. The word is transferred when out_valid && out_ready.
slot  output  CW  number of bits collected in the current frame; 0 in IDLE.
frame_err  output  1  one-cycle pulse when a frame is abandoned by an early in_sof.

Behaviour:
- Reset:
  - rst sampled high: state=IDLE, cnt=0, asm=0, out_data=0, out_valid=0, frame_err=0, slot=0.
  - in_ready=0 while rst is high and 1 in the first cycle after.
  - Reset mid-frame discards the partial frame and any held word, with no error pulse.
- Registers:
  - asm[WIDTH-1:0] is the assembly register.
  - cnt[CW:0] is the slot counter.
  - state is one of IDLE, COLLECT, FULL.
  - The output register drives out_data/out_valid.
- in_ready = !rst && state!=FULL. It is combinational from state.
- IDLE:
  - Accepted beat with in_sof=0: dropped silently.
  - Accepted beat with in_sof=1: writes slot 0, cnt<=1, go COLLECT.
- COLLECT:
  - Accepted beat with in_sof=0: writes slot cnt, cnt<=cnt+1.
  - Accepted beat with in_sof=1 (any cnt, including cnt==WIDTH-1): frame_err<=1 for one cycle, partial frame discarded, bit written to slot 0, cnt<=1, stay COLLECT.
- Completion:
  - The beat that writes slot WIDTH-1 with in_sof=0 completes the frame.
  - If the output register is free (out_valid==0, or out_valid&&out_ready this cycle), the completed word, including the bit just accepted, loads into out_data. out_valid<=1, cnt<=0, go IDLE.
  - Otherwise go FULL, holding asm.
- FULL:
  - in_ready=0.
  - When the output register frees, asm loads into out_data, out_valid<=1, cnt<=0, go IDLE.
- Output port:
  - out_valid clears on transfer unless a new word loads the same edge.
  - out_data and out_valid are stable while out_valid && !out_ready.
  - No combinational path from out_ready to out_data/out_valid.
- Latency:
  - Last bit accepted at edge N gives out_valid=1 after edge N when the output register is free.
  - Otherwise it loads on the edge after the transfer that frees it.
- Throughput:
  - Sustains one bit per cycle.
  - A new frame's in_sof may be accepted the cycle after completion.
  - Capacity is two words (output register plus asm in FULL).
- Slots are indexed 0..WIDTH-1 with no wrap-around; cnt never exceeds WIDTH-1 in COLLECT.
- No X propagation: in_bit is sampled only on accepted beats.

Test Plan:
- Frame 16'h3F0A, MSB_FIRST=0, bits sent LSB-first with in_sof on bit 0, out_ready=1 -> out_valid=1 one cycle after bit 15 accepted, out_data=16'h3F0A, slot counts 1..15 then 0.
- Same bit stream into a MSB_FIRST=1 instance -> out_data=16'h50FC (bit-reversed 3F0A).
- Back-to-back frames 16'h0006 and 16'h000C with out_ready=0 -> first word held in output register, second enters FULL, in_ready=0. Raise out_ready for 2 cycles -> 16'h0006 then 16'h000C transfer, in_ready returns to 1.
- Five beats with in_sof=0 before any in_sof -> all dropped, slot=0. Then a valid frame of 16'hFFFF -> out_data=16'hFFFF.
- Frame aborted by in_sof at slot 7, then full frame 16'hA5A5 -> frame_err pulses exactly one cycle, output is 16'hA5A5 only, with no word emitted for the aborted frame.
- rst asserted for one cycle at slot 9 with a word held and out_ready=0 -> next cycle out_valid=0, out_data=0, slot=0, in_ready=1, frame_err=0.
